// File: rtl/dbus_pkg.sv
// dbus_pkg: shared state encoding, memory-map constants and default widths for the data bus arbiter.
package dbus_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] DMEM_BASE = 32'h0;
  localparam logic [31:0] PERIPH_WR_BASE = 32'h40000;
  localparam logic [31:0] PERIPH_RD_BASE = 32'h40004;
  typedef enum logic [1:0] {ARB_IDLE, ARB_G0, ARB_G1} arb_state_e;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way winner select, round-robin on last holder; ARB_FIXED_PRIO_EN makes master 0 win every tie.
module arb_rr2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
  assign winner = req1 & ~req0;
`else
  assign winner = (req0 & req1) ? ~last : req1;
`endif
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master req/gnt arbiter with bounded bursts in front of the BIU data port.
// Build with ARB_FIXED_PRIO_EN for master-0 fixed priority instead of round-robin.
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [3:0]        we0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        we1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  output logic [3:0]        dwe,
  input  logic [DATA_W-1:0] drdata,
  output logic              owner,
  output logic              busy
);
  localparam int CW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX - 1);
  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic last_q, last_d, owner_q, owner_d;
  logic cur, req_cur, win;
  assign busy = state_q != ARB_IDLE;
  assign gnt0 = state_q == ARB_G0;
  assign gnt1 = state_q == ARB_G1;
  assign owner = owner_q;
  assign cur = gnt1;
  assign req_cur = cur ? req1 : req0;
  // While granted, ask the selector who would win if the holder were "last": that yields the handover target.
  arb_rr2 u_rr (.req0(req0), .req1(req1), .last(busy ? cur : last_q), .winner(win));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    if (!busy) begin
      if (req0 | req1) state_d = win ? ARB_G1 : ARB_G0;
    end else if (!req_cur || (cnt_q == CMAX && win != cur)) begin
      state_d = !(req0 | req1) ? ARB_IDLE : (win ? ARB_G1 : ARB_G0);
      last_d = cur;
      cnt_d = '0;
    end else begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
    end
    owner_d = (state_d == ARB_G0) ? 1'b0 : (state_d == ARB_G1) ? 1'b1 : last_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      cnt_q <= '0;
      last_q <= 1'b1;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      owner_q <= owner_d;
    end
  end
  assign daddr = busy ? (cur ? addr1 : addr0) : '0;
  assign dwdata = busy ? (cur ? wdata1 : wdata0) : '0;
  assign dwe = (busy && req_cur) ? (cur ? we1 : we0) : '0;
  assign rdata = busy ? drdata : '0;
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed plus random stimulus, reference model feeds a scoreboard checked every cycle.
module tb_dbus_arbiter;
  localparam int BM = 8;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {
    logic g0, g1, busy, own;
    logic [31:0] da, dwd, rd;
    logic [3:0] dw;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0 = 0, req1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, drdata = 0;
  logic [3:0] we0 = 0, we1 = 0;
  logic gnt0, gnt1, owner, busy;
  logic [31:0] rdata, daddr, dwdata;
  logic [3:0] dwe;
  int checks = 0, errors = 0;
  exp_t q[$];
  int hold, run, lastm, own;
  always #5 clk = ~clk;
  dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .gnt1(gnt1),
    .rdata(rdata), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
    .owner(owner), .busy(busy)
  );
  function automatic void cmp(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic void model_reset();
    hold = -1; run = 0; lastm = 1; own = 0;
  endfunction
  function automatic void model_edge();
    logic r[2];
    r[0] = req0; r[1] = req1;
    if (hold < 0) begin
      if (r[0] && r[1]) hold = FIXED ? 0 : 1 - lastm;
      else if (r[0]) hold = 0;
      else if (r[1]) hold = 1;
      run = 0;
    end else if (!r[hold]) begin
      lastm = hold;
      hold = r[1 - hold] ? 1 - hold : -1;
      run = 0;
    end else begin
      run++;
      if (r[1 - hold] && run >= BM && (!FIXED || hold == 1)) begin
        lastm = hold;
        hold = 1 - hold;
        run = 0;
      end
    end
    own = (hold >= 0) ? hold : lastm;
  endfunction
  function automatic exp_t expect_now();
    exp_t e;
    e.busy = hold >= 0;
    e.g0 = hold == 0;
    e.g1 = hold == 1;
    e.own = own[0];
    e.da = (hold == 0) ? addr0 : (hold == 1) ? addr1 : 32'h0;
    e.dwd = (hold == 0) ? wdata0 : (hold == 1) ? wdata1 : 32'h0;
    e.dw = (hold == 0 && req0) ? we0 : (hold == 1 && req1) ? we1 : 4'h0;
    e.rd = (hold >= 0) ? drdata : 32'h0;
    return e;
  endfunction
  task automatic step(input logic r0, input logic [31:0] a0, wd0, input logic [3:0] w0,
                      input logic r1, input logic [31:0] a1, wd1, input logic [3:0] w1,
                      input logic [31:0] dr);
    @(posedge clk);
    if (reset) model_edge();
    else model_reset();
    #1;
    req0 = r0; addr0 = a0; wdata0 = wd0; we0 = w0;
    req1 = r1; addr1 = a1; wdata1 = wd1; we1 = w1;
    drdata = dr;
    q.push_back(expect_now());
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp("gnt0", 32'(gnt0), 32'(e.g0));
      cmp("gnt1", 32'(gnt1), 32'(e.g1));
      cmp("busy", 32'(busy), 32'(e.busy));
      cmp("owner", 32'(owner), 32'(e.own));
      cmp("daddr", daddr, e.da);
      cmp("dwdata", dwdata, e.dwd);
      cmp("dwe", 32'(dwe), 32'(e.dw));
      cmp("rdata", rdata, e.rd);
    end
  end
  initial begin
    int p0, p1;
    model_reset();
    #1 reset = 1'b0;
    repeat (3) step(1, 32'h100, 32'h11, 4'h3, 1, 32'h200, 32'h22, 4'hC, 32'hAA);
    @(negedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 26; i++) step(1, 32'h100 + i, i, 4'hF, 1, 32'h200 + i, 32'h900 + i, 4'h1, 32'h55 + i);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 32'h40000, 32'd5, 4'hF, 0, 0, 0, 0, 32'h7);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 32'h40004, 32'h0, 4'h0, 32'h1234);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h10, 32'h1, 4'h5, 0, 0, 0, 0, 0);
    step(1, 32'h10, 32'h1, 4'h5, 1, 32'h20, 32'h2, 4'hA, 0);
    step(0, 32'h10, 32'h1, 4'h5, 1, 32'h20, 32'h2, 4'hA, 0);
    repeat (2) step(0, 0, 0, 0, 1, 32'h20, 32'h2, 4'hA, 32'h3);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 1, 32'h40000, 32'h77, 4'hF, 0);
    @(negedge clk); #2 reset = 1'b0;
    model_reset();
    #1;
    cmp("async_rst_dwe", 32'(dwe), 32'h0);
    cmp("async_rst_gnt1", 32'(gnt1), 32'h0);
    cmp("async_rst_busy", 32'(busy), 32'h0);
    repeat (2) step(1, 32'h30, 32'h3, 4'h2, 1, 32'h40, 32'h4, 4'h4, 0);
    @(negedge clk); #2 reset = 1'b1;
    repeat (3) step(1, 32'h30, 32'h3, 4'h2, 1, 32'h40, 32'h4, 4'h4, 0);
    p0 = 50; p1 = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 0) begin
        p0 = (i % 240 == 0) ? 100 : 30 * $urandom_range(0, 3);
        p1 = (i % 240 == 0) ? 100 : 30 * $urandom_range(0, 3);
      end
      step($urandom_range(0, 99) < p0, $urandom, $urandom, 4'($urandom),
           $urandom_range(0, 99) < p1, $urandom, $urandom, 4'($urandom), $urandom);
    end
    @(negedge clk); #1;
    cmp("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
